// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that gives two requesters turns on one combinational ALU and returns registered results.
// States: IDLE arbitrate/accept | EXEC drive ALU one cycle | RESP hold response until taken.
module alu_share_arbiter #(
    parameter int                DATA_W = 32,
    parameter int                CTRL_W = 6,
    parameter logic [CTRL_W-1:0] MAX_OP = CTRL_W'(36)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic [CTRL_W-1:0] rq0_ctrl,
    input  logic [DATA_W-1:0] rq0_a,
    input  logic [DATA_W-1:0] rq0_b,
    output logic              rs0_valid,
    input  logic              rs0_ready,
    output logic [DATA_W-1:0] rs0_result,
    output logic              rs0_zero,
    output logic              rs0_err,

    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic [CTRL_W-1:0] rq1_ctrl,
    input  logic [DATA_W-1:0] rq1_a,
    input  logic [DATA_W-1:0] rq1_b,
    output logic              rs1_valid,
    input  logic              rs1_ready,
    output logic [DATA_W-1:0] rs1_result,
    output logic              rs1_zero,
    output logic              rs1_err,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              busy,
    output logic              grant_id
);

    localparam logic [CTRL_W-1:0] OP_LUI   = CTRL_W'(33);
    localparam logic [CTRL_W-1:0] OP_AUIPC = CTRL_W'(34);
    localparam logic [CTRL_W-1:0] OP_JAL   = CTRL_W'(35);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_ptr;
    logic              r_grant;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [CTRL_W-1:0] r_op_ctrl;
    logic [DATA_W-1:0] r_res [2];
    logic [1:0]        r_zero;
    logic [1:0]        r_err;

    logic              w_win;
    logic              w_any;
    logic              w_accept;
    logic              w_legal;
    logic              w_rs_done;
    logic [1:0]        w_rq_ready;
    logic [1:0]        w_rs_valid;
    logic [CTRL_W-1:0] w_win_ctrl;
    logic [DATA_W-1:0] w_win_a;
    logic [DATA_W-1:0] w_win_b;

    // Pointer only matters on contention; a lone requester always wins.
    assign w_any      = rq0_valid | rq1_valid;
    assign w_win      = (rq0_valid & rq1_valid) ? r_ptr : rq1_valid;
    assign w_win_ctrl = w_win ? rq1_ctrl : rq0_ctrl;
    assign w_win_a    = w_win ? rq1_a    : rq0_a;
    assign w_win_b    = w_win ? rq1_b    : rq0_b;
    assign w_legal    = (w_win_ctrl <= MAX_OP) && (w_win_ctrl != OP_LUI) &&
                        (w_win_ctrl != OP_AUIPC) && (w_win_ctrl != OP_JAL);
    assign w_rs_done  = r_grant ? rs1_ready : rs0_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rq_ready   = 2'b00;
        w_rs_valid   = 2'b00;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any && rst_n) begin
                    w_rq_ready[w_win] = 1'b1;
                    w_accept          = 1'b1;
                    w_next_state      = w_legal ? S_EXEC : S_RESP;
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_rs_valid[r_grant] = 1'b1;
                if (w_rs_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Illegal ops never reach the ALU pins, so the operand registers load only on legal accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= 1'b0;
            r_grant   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_ctrl <= '0;
            r_res[0]  <= '0;
            r_res[1]  <= '0;
            r_zero    <= 2'b00;
            r_err     <= 2'b00;
        end else begin
            if (w_accept) begin
                r_grant <= w_win;
                if (w_legal) begin
                    r_op_a    <= w_win_a;
                    r_op_b    <= w_win_b;
                    r_op_ctrl <= w_win_ctrl;
                end else begin
                    r_res[w_win]  <= '0;
                    r_zero[w_win] <= 1'b0;
                    r_err[w_win]  <= 1'b1;
                end
            end
            if (r_state == S_EXEC) begin
                r_res[r_grant]  <= alu_result;
                r_zero[r_grant] <= alu_zero;
                r_err[r_grant]  <= 1'b0;
            end
            if ((r_state == S_RESP) && w_rs_done) begin
                r_ptr <= ~r_grant;
            end
        end
    end

    assign rq0_ready   = w_rq_ready[0];
    assign rq1_ready   = w_rq_ready[1];
    assign rs0_valid   = w_rs_valid[0];
    assign rs1_valid   = w_rs_valid[1];
    assign rs0_result  = r_res[0];
    assign rs1_result  = r_res[1];
    assign rs0_zero    = r_zero[0];
    assign rs1_zero    = r_zero[1];
    assign rs0_err     = r_err[0];
    assign rs1_err     = r_err[1];
    assign alu_a       = r_op_a;
    assign alu_b       = r_op_b;
    assign alu_control = r_op_ctrl;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the execute path, requester 1 is the branch/address helper.
- Arbitrates with round-robin priority and latches the winner's operands and opcode.
- Drives the ALU for one cycle, registers alu_result and zero, then returns them to the winner over a valid/ready response handshake.
- Sits between the requesters and the ALU instance. It owns the ALU input pins exclusively.

Parameters:
- DATA_W, 32, operand and result width.
- CTRL_W, 6, ALU opcode width. Uses the ALU's 6-bit operation encoding.
- MAX_OP, 6'd36, highest legal opcode (JALR).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- rq0_valid  in  1  requester 0 has an operation.
- rq0_ready  out  1  requester 0 operation accepted this cycle.
- rq0_ctrl  in  CTRL_W  requester 0 opcode.
- rq0_a, rq0_b  in  DATA_W  requester 0 operands.
- rs0_valid  out  1  response to requester 0 valid.
- rs0_ready  in  1  requester 0 takes the response.
- rs0_result  out  DATA_W  registered ALU result.
- rs0_zero  out  1  registered zero flag.
- rs0_err  out  1  illegal or non-ALU opcode.
- rq1_*/rs1_*  same set as above, for requester 1.
- alu_a, alu_b  out  DATA_W  to ALU inputs A and B.
- alu_control  out  CTRL_W  to ALU alu_control.
- alu_result  in  DATA_W  from ALU.
- alu_zero  in  1  from ALU zero.
- busy  out  1  state is not IDLE.
- grant_id  out  1  index of the current or last winner.

Behaviour:
- Reset (rst_n low at a clk edge) forces:
  - state=IDLE, priority pointer=0 (requester 0 favoured), grant_id=0.
  - all rq*_ready=0, all rs*_valid=0, rs*_result=0, rs*_zero=0, rs*_err=0.
  - alu_a=0, alu_b=0, alu_control=0.
- Reset mid-operation discards the in-flight op. No response is issued.
- States: IDLE -> EXEC -> RESP -> IDLE. ERR path: IDLE -> RESP.
- IDLE:
  - If exactly one rq*_valid is high, that requester wins.
  - If both are high, the pointer's requester wins.
  - The winner's rq_ready is a combinational 1-cycle pulse in IDLE. The transfer occurs when valid&ready at the edge.
  - At that edge, latch ctrl/a/b into operand registers and set grant_id.
  - Legal opcode (ctrl<=MAX_OP and not LUI 33/AUIPC 34/JAL 35): go to EXEC.
  - Otherwise: set err=1, result=0, zero=0, go to RESP.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_control come from the operand registers, which are stable the whole cycle.
  - At the edge, capture alu_result and alu_zero into the winner's rs registers, err=0, go to RESP.
- RESP:
  - The winner's rs_valid=1. rs_valid, rs_result, rs_zero and rs_err hold stable until rs_ready=1.
  - On rs_valid&rs_ready: clear rs_valid, set pointer = ~grant_id, go to IDLE.
- Outside EXEC, alu_control is held at its last value and operands are held. The ALU output is ignored.
- No rq_ready is given outside IDLE. Requests stall while busy and must hold valid/operands; the bench checks the hold.
- Latency, legal op: accept edge T, result captured at T+1, rs_valid high in cycle T+1..T+2 (visible after T+1 edge). Minimum issue interval is 3 cycles (accept, EXEC, RESP with immediate ready).
- Illegal op: rs_valid is visible after the accept edge, 2-cycle turnaround.
- The non-granted requester's rs_valid is always 0.
- The pointer updates only on response completion. A lone requester may win back-to-back.
- Widths: operands pass unmodified. No sign extension or masking in this block.

Test Plan:
- Reset then single op: rq0 ctrl=0 (ADD), a=5, b=7 -> rq0_ready pulses once; 2 cycles later rs0_valid=1, rs0_result=12, rs0_zero=0, rs0_err=0; rs1_valid stays 0.
- Simultaneous requests after reset: rq0 SUB(10,3), rq1 BEQ(4,4) both held -> rq0 served first (result 7). Then rq1 is served with result 1, zero=1, grant_id=1. Next contention goes to rq0.
- Back-pressure: rs1_ready held low 5 cycles after rs1_valid -> rs1_valid/result stable all 5 cycles, busy=1, rq0 not accepted until the cycle after rs1_ready.
- Illegal op: rq1 ctrl=6'd35 (JAL), then ctrl=6'd50 -> each gives rs1_err=1, result=0, no EXEC cycle, and alu_control never shows 35 or 50.
- Reset mid-EXEC: rst_n low for 1 cycle during EXEC -> no rs*_valid; all outputs return to reset values; pointer=0; next request proceeds normally.
- ALU drive: rq0 SRA a=32'h80000000 b=4 -> alu_a/alu_b/alu_control stable in EXEC; rs0_result=32'hF8000000.
